// File: rtl/clk_gate_ctrl.sv
// clk_gate_ctrl: per-domain clock-gate sequencer.
//
// Each domain runs an independent ON -> QUIESCE -> OFF -> WAKE -> ON sequence.
// A domain is gated after it has stayed idle (and gating is permitted) for more
// than cfg_idle_thresh_i cycles and it has acknowledged a quiesce request. A wake
// request or withdrawal of gating permission re-enables the clock, and ready_o
// follows WAKE_CYCLES cycles later.
//
// Ports:
//   clk_i              free-running (ungated) clock
//   rst_ni             asynchronous active-low reset
//   test_en_i          test mode, forces every en_o high
//   cfg_gate_en_i      per-domain permission to gate
//   cfg_idle_thresh_i  idle cycles required before quiesce (shared)
//   idle_i             per-domain idle indication
//   wake_i             per-domain wake request (level)
//   quiesce_req_o      per-domain request to reach a safe stop point
//   quiesce_ack_i      per-domain quiesce acknowledge
//   en_o               per-domain clock enable to the gate cell
//   ready_o            per-domain clock running and stable
//   gated_o            per-domain clock currently gated
module clk_gate_ctrl #(
    parameter int unsigned NUM_DOMAINS = 4,
    parameter int unsigned IDLE_CNT_W  = 8,
    parameter int unsigned WAKE_CYCLES = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   test_en_i,
    input  logic [NUM_DOMAINS-1:0] cfg_gate_en_i,
    input  logic [IDLE_CNT_W-1:0]  cfg_idle_thresh_i,
    input  logic [NUM_DOMAINS-1:0] idle_i,
    input  logic [NUM_DOMAINS-1:0] wake_i,
    output logic [NUM_DOMAINS-1:0] quiesce_req_o,
    input  logic [NUM_DOMAINS-1:0] quiesce_ack_i,
    output logic [NUM_DOMAINS-1:0] en_o,
    output logic [NUM_DOMAINS-1:0] ready_o,
    output logic [NUM_DOMAINS-1:0] gated_o
);

    typedef enum logic [1:0] {
        StOn      = 2'd0,
        StQuiesce = 2'd1,
        StOff     = 2'd2,
        StWake    = 2'd3
    } state_e;

    localparam logic [7:0] WakeLoad = 8'(WAKE_CYCLES);

    for (genvar d = 0; d < NUM_DOMAINS; d++) begin : g_dom
        state_e                state_q, state_d;
        logic [IDLE_CNT_W-1:0] idle_cnt_q, idle_cnt_d;
        logic [7:0]            wake_cnt_q, wake_cnt_d;
        logic                  en_q, en_d;
        logic                  ready_q, ready_d;
        logic                  req_q, req_d;
        logic                  gated_q, gated_d;
        logic                  go;

        assign go = cfg_gate_en_i[d] & idle_i[d] & ~wake_i[d];

        always_comb begin
            state_d    = state_q;
            idle_cnt_d = '0;
            wake_cnt_d = wake_cnt_q;

            unique case (state_q)
                StOn: begin
                    if (go) begin
                        // >= so that lowering the threshold mid-count still triggers.
                        if (idle_cnt_q >= cfg_idle_thresh_i) begin
                            state_d = StQuiesce;
                        end else if (idle_cnt_q != {IDLE_CNT_W{1'b1}}) begin
                            idle_cnt_d = idle_cnt_q + 1'b1;
                        end else begin
                            idle_cnt_d = idle_cnt_q;
                        end
                    end
                end
                StQuiesce: begin
                    // Abort wins over a same-cycle acknowledge.
                    if (!go) begin
                        state_d = StOn;
                    end else if (quiesce_ack_i[d]) begin
                        state_d = StOff;
                    end
                end
                StOff: begin
                    if (wake_i[d] || !cfg_gate_en_i[d]) begin
                        state_d    = StWake;
                        wake_cnt_d = WakeLoad;
                    end
                end
                StWake: begin
                    if (wake_cnt_q <= 8'd1) begin
                        state_d    = StOn;
                        wake_cnt_d = '0;
                    end else begin
                        wake_cnt_d = wake_cnt_q - 8'd1;
                    end
                end
                default: begin
                    state_d = StOn;
                end
            endcase

            // Outputs are registered from the next state so they line up with state_q.
            en_d    = (state_d != StOff);
            ready_d = (state_d == StOn) || (state_d == StQuiesce);
            req_d   = (state_d == StQuiesce);
            gated_d = (state_d == StOff);
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                state_q    <= StOn;
                idle_cnt_q <= '0;
                wake_cnt_q <= '0;
                en_q       <= 1'b1;
                ready_q    <= 1'b1;
                req_q      <= 1'b0;
                gated_q    <= 1'b0;
            end else begin
                state_q    <= state_d;
                idle_cnt_q <= idle_cnt_d;
                wake_cnt_q <= wake_cnt_d;
                en_q       <= en_d;
                ready_q    <= ready_d;
                req_q      <= req_d;
                gated_q    <= gated_d;
            end
        end

        // Test mode bypasses the FSM on the enable only; status stays truthful.
        assign en_o[d]          = en_q | test_en_i;
        assign ready_o[d]       = ready_q;
        assign quiesce_req_o[d] = req_q;
        assign gated_o[d]       = gated_q;
    end

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Randomised bench for clk_gate_ctrl with a cycle-level behavioural model.
module tb_clk_gate_ctrl;

    localparam int ND = 4;
    localparam int IW = 8;
    localparam int WC = 4;
    localparam int IdleMax = (1 << IW) - 1;

    localparam int MOn   = 0;
    localparam int MReq  = 1;
    localparam int MOff  = 2;
    localparam int MWake = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          test_en;
    logic [ND-1:0] cfg_gate_en;
    logic [IW-1:0] thresh;
    logic [ND-1:0] idle;
    logic [ND-1:0] wake;
    logic [ND-1:0] ack;
    logic [ND-1:0] req_o;
    logic [ND-1:0] en_o;
    logic [ND-1:0] ready_o;
    logic [ND-1:0] gated_o;

    always #5 clk = ~clk;

    clk_gate_ctrl #(
        .NUM_DOMAINS(ND),
        .IDLE_CNT_W (IW),
        .WAKE_CYCLES(WC)
    ) u_dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .test_en_i        (test_en),
        .cfg_gate_en_i    (cfg_gate_en),
        .cfg_idle_thresh_i(thresh),
        .idle_i           (idle),
        .wake_i           (wake),
        .quiesce_req_o    (req_o),
        .quiesce_ack_i    (ack),
        .en_o             (en_o),
        .ready_o          (ready_o),
        .gated_o          (gated_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model: mode per domain, idle-run length, and the cycle at which a wake completes.
    int mode[ND];
    int idle_run[ND];
    int ready_at[ND];
    int cyc = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < ND; i++) begin
            mode[i]     = MOn;
            idle_run[i] = 0;
            ready_at[i] = 0;
        end
    endtask

    task automatic model_step();
        bit go;
        cyc++;
        for (int i = 0; i < ND; i++) begin
            go = cfg_gate_en[i] && idle[i] && !wake[i];
            case (mode[i])
                MOn: begin
                    if (!go) idle_run[i] = 0;
                    else if (idle_run[i] >= int'(thresh)) begin
                        mode[i]     = MReq;
                        idle_run[i] = 0;
                    end else if (idle_run[i] < IdleMax) idle_run[i]++;
                end
                MReq: begin
                    if (!go) mode[i] = MOn;
                    else if (ack[i]) mode[i] = MOff;
                end
                MOff: begin
                    if (wake[i] || !cfg_gate_en[i]) begin
                        mode[i]     = MWake;
                        ready_at[i] = cyc + WC;
                    end
                end
                default: begin
                    if (cyc >= ready_at[i]) mode[i] = MOn;
                end
            endcase
        end
    endtask

    task automatic check_outputs(input string ph);
        logic [ND-1:0] e_en, e_rdy, e_req, e_gt;
        for (int i = 0; i < ND; i++) begin
            e_en[i]  = (mode[i] != MOff) || test_en;
            e_rdy[i] = (mode[i] == MOn) || (mode[i] == MReq);
            e_req[i] = (mode[i] == MReq);
            e_gt[i]  = (mode[i] == MOff);
        end
        check_eq({ph, "/en_o"}, 32'(en_o), 32'(e_en));
        check_eq({ph, "/ready_o"}, 32'(ready_o), 32'(e_rdy));
        check_eq({ph, "/quiesce_req_o"}, 32'(req_o), 32'(e_req));
        check_eq({ph, "/gated_o"}, 32'(gated_o), 32'(e_gt));
    endtask

    task automatic drive_random();
        for (int i = 0; i < ND; i++) begin
            idle[i]        = ($urandom_range(0, 7) != 0);
            wake[i]        = ($urandom_range(0, 15) == 0);
            cfg_gate_en[i] = ($urandom_range(0, 15) != 0);
            ack[i]         = $urandom_range(0, 1) != 0;
        end
        test_en = ($urandom_range(0, 9) == 0);
        if ($urandom_range(0, 49) == 0) thresh = IW'($urandom_range(0, 6));
    endtask

    initial begin
        bit any_wake;
        rst_n = 1'b0;
        thresh = IW'(3);
        drive_random();
        model_reset();
        // Reset holds regardless of input activity.
        repeat (3) begin
            @(negedge clk);
            drive_random();
            test_en = 1'b0;
            #1;
            check_outputs("reset");
        end
        @(negedge clk);
        rst_n = 1'b1;

        for (int n = 0; n < 3000; n++) begin
            if (n != 0) @(negedge clk);
            drive_random();
            any_wake = 1'b0;
            for (int i = 0; i < ND; i++) if (mode[i] == MWake) any_wake = 1'b1;
            if ((any_wake && $urandom_range(0, 9) == 0) || $urandom_range(0, 299) == 0) begin
                // Asynchronous reset between edges must take effect at once.
                rst_n = 1'b0;
                #1;
                model_reset();
                check_outputs("async_rst");
                @(posedge clk);
                #1;
                check_outputs("rst_hold");
                @(negedge clk);
                rst_n = 1'b1;
                drive_random();
            end
            #1;
            check_outputs("run");
            @(posedge clk);
            model_step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
